playfield_renderer: RTL and testbench
=====================================

// Module: playfield_renderer
// PURPOSE
//  Pipelined per-pixel renderer for the Tetris playfield: walls of parametrised thickness, interior cells from board RAM, grid lines, line-clear flash.
//  Sits between the VGA timing generator (xaddr/yaddr) and the pixel mux; reads settled-block occupancy one row at a time from board RAM.
//  The flash FSM blinks rows marked for clearing over a fixed number of frames, then pulses flash_done to the game controller.
// PARAMETERS
//  X_START       470      left edge of outer wall, pixels
//  Y_START       100      top edge of outer wall, pixels
//  BLOCK         30       cell size, pixels (square)
//  COLS          10       interior columns
//  ROWS          20       interior rows
//  WALL          1        wall thickness, in blocks (>=1)
//  GRID_EN       1        1: draw 1-px grid line on first pixel row/col of each empty interior cell
//  FLASH_PERIOD  8        frames per flash phase (>=1)
//  FLASH_TOGGLES 6        phase toggles per flash sequence (>=1)
//  WALL_COLOR    12'h333  BG_COLOR 12'h000  CELL_COLOR 12'hF80  GRID_COLOR 12'h111  FLASH_COLOR 12'hFFF
// PORTS
//  clk          in   1         pixel clock
//  rst          in   1         synchronous reset, active-high
//  xaddr        in   11        current pixel x
//  yaddr        in   10        current pixel y
//  frame_start  in   1         one-cycle pulse at start of each frame
//  row_addr     out  clog2(ROWS)  board RAM row address
//  row_data     in   COLS      board RAM data, valid 1 cycle after row_addr; bit c = column c (col 0 leftmost)
//  flash_req    in   1         one-cycle pulse: start flash sequence
//  flash_mask   in   ROWS      rows to flash, sampled with flash_req; bit r = row r (row 0 top)
//  flash_busy   out  1         flash sequence in progress
//  flash_done   out  1         one-cycle pulse when sequence ends
//  on_board     out  1         pixel inside outer wall boundary (wall or interior)
//  is_wall      out  1         pixel is wall
//  pix_color    out  12        RGB444 color; BG_COLOR when on_board=0
// BEHAVIOUR
//  Reset: all outputs 0 (pix_color=0, row_addr=0, flash_busy=0, flash_done=0), FSM IDLE, counters 0.
//  Geometry: outer box X_START..X_START+(COLS+2*WALL)*BLOCK-1, Y_START..Y_START+(ROWS+2*WALL)*BLOCK-1, lower bounds inclusive, upper exclusive.
//    Wall = outer box minus interior; interior offset by WALL*BLOCK on every side.
//  Pipeline, fixed latency 2 clk: outputs at cycle N+2 describe xaddr/yaddr sampled at N.
//    S1 (N->N+1): classify region; compute col=(x-X_START)/BLOCK-WALL, row likewise, in-cell offsets; register; drive row_addr=row (hold previous when not interior).
//    S2 (N+1->N+2): select row_data[col]; resolve color by priority; register outputs.
//  Color priority: wall > flash (interior, row masked, phase=1) > occupied cell > grid (GRID_EN, offset x==0 or y==0) > BG_COLOR.
//  Outside outer box: on_board=0, is_wall=0, pix_color=BG_COLOR. No wrap: x,y below start never alias.
//  Flash FSM: IDLE -> FLASH on flash_req (latch mask, phase=1, frame_cnt=0, tog_cnt=0, flash_busy=1 next cycle).
//    FLASH: each frame_start increments frame_cnt; at frame_cnt==FLASH_PERIOD-1 the same pulse clears frame_cnt, toggles phase, increments tog_cnt.
//    Toggle number FLASH_TOGGLES -> DONE (phase=0); DONE lasts one cycle with flash_done=1, flash_busy=0, then IDLE.
//    flash_req while busy or in DONE: ignored, mask unchanged. flash_req with mask=0: full sequence runs, nothing visible.
//    Simultaneous flash_req and frame_start in IDLE: request accepted; that frame_start not counted.
//  rst mid-sequence: back to IDLE, flash_busy=0, no flash_done pulse; pipeline contents discarded (outputs 0).
// TESTING
//  After rst: x=470,y=100 -> 2 clk later is_wall=1,on_board=1,pix_color=12'h333; x=469 -> on_board=0,pix_color=0.
//  Right edge: x=829,y=200 -> is_wall=1; x=830,y=200 -> on_board=0; bottom y=759 wall, y=760 outside.
//  Interior x=505,y=135: row_addr=0; row_data=10'b1 -> CELL_COLOR 12'hF80; row_data=0 -> BG_COLOR; x=500,y=135 (offset 0) -> GRID_COLOR.
//  FLASH_PERIOD=2, FLASH_TOGGLES=2, flash_mask bit19: flash_busy=1 next cycle; pixel x=505,y=705 FLASH_COLOR for 2 frames then BG_COLOR;
//    flash_done one cycle after 4th frame_start; row 18 pixel unaffected throughout.
//  flash_req during FLASH with new mask -> ignored, original timing and mask kept.
//  rst asserted after 3 frame_starts of a sequence -> flash_busy=0, no flash_done, outputs 0; new flash_req restarts from phase=1.

Source files
------------

// File: rtl/playfield_renderer.sv
// Per-pixel playfield renderer: walls, board cells, grid lines and line-clear flash.
// Two-stage pipeline from xaddr/yaddr to pix_color, plus the flash sequencing FSM.
module playfield_renderer #(
   parameter int unsigned X_START       = 470,
   parameter int unsigned Y_START       = 100,
   parameter int unsigned BLOCK         = 30,
   parameter int unsigned COLS          = 10,
   parameter int unsigned ROWS          = 20,
   parameter int unsigned WALL          = 1,
   parameter bit          GRID_EN       = 1'b1,
   parameter int unsigned FLASH_PERIOD  = 8,
   parameter int unsigned FLASH_TOGGLES = 6,
   parameter logic [11:0] WALL_COLOR    = 12'h333,
   parameter logic [11:0] BG_COLOR      = 12'h000,
   parameter logic [11:0] CELL_COLOR    = 12'hF80,
   parameter logic [11:0] GRID_COLOR    = 12'h111,
   parameter logic [11:0] FLASH_COLOR   = 12'hFFF,
   localparam int unsigned ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      xaddr,
   input  logic [9:0]       yaddr,
   input  logic             frame_start,
   output logic [ROW_W-1:0] row_addr,
   input  logic [COLS-1:0]  row_data,
   input  logic             flash_req,
   input  logic [ROWS-1:0]  flash_mask,
   output logic             flash_busy,
   output logic             flash_done,
   output logic             on_board,
   output logic             is_wall,
   output logic [11:0]      pix_color
);

   localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned FC_W  = $clog2(FLASH_PERIOD + 1);
   localparam int unsigned TC_W  = $clog2(FLASH_TOGGLES + 1);

   // One extra bit of headroom so the upper box bounds never overflow.
   localparam logic [11:0] X_LO    = 12'(X_START);
   localparam logic [11:0] X_HI    = 12'(X_START + (COLS + 2 * WALL) * BLOCK);
   localparam logic [11:0] BLK_X   = 12'(BLOCK);
   localparam logic [11:0] IX_LO   = 12'(WALL);
   localparam logic [11:0] IX_HI   = 12'(WALL + COLS);
   localparam logic [10:0] Y_LO    = 11'(Y_START);
   localparam logic [10:0] Y_HI    = 11'(Y_START + (ROWS + 2 * WALL) * BLOCK);
   localparam logic [10:0] BLK_Y   = 11'(BLOCK);
   localparam logic [10:0] IY_LO   = 11'(WALL);
   localparam logic [10:0] IY_HI   = 11'(WALL + ROWS);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_PERIOD - 1);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(FLASH_TOGGLES - 1);

   typedef enum logic [1:0] {StIdle, StFlash, StDone} flash_state_e;

   // ---------------- Stage 1: region classification ----------------
   logic [11:0]      x_ext, dx, bx, ox;
   logic [10:0]      y_ext, dy, by, oy;
   logic             in_box, in_int, on_grid;
   logic [COL_W-1:0] col_c;
   logic [ROW_W-1:0] row_c;

   always_comb begin
      x_ext   = {1'b0, xaddr};
      y_ext   = {1'b0, yaddr};
      dx      = x_ext - X_LO;
      dy      = y_ext - Y_LO;
      bx      = dx / BLK_X;
      by      = dy / BLK_Y;
      ox      = dx % BLK_X;
      oy      = dy % BLK_Y;
      // Lower-bound tests come first, so coordinates left of / above the box never wrap in.
      in_box  = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
      in_int  = in_box && (bx >= IX_LO) && (bx < IX_HI) && (by >= IY_LO) && (by < IY_HI);
      on_grid = (ox == '0) || (oy == '0);
      col_c   = COL_W'(bx - IX_LO);
      row_c   = ROW_W'(by - IY_LO);
   end

   logic [ROW_W-1:0] row_q;

   // Board RAM address is presented in stage 1 so its data lines up with stage 2.
   assign row_addr = rst ? '0 : (in_int ? row_c : row_q);

   logic             s1_box_q, s1_int_q, s1_grid_q;
   logic [COL_W-1:0] s1_col_q;
   logic [ROW_W-1:0] s1_row_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q     <= '0;
         s1_box_q  <= 1'b0;
         s1_int_q  <= 1'b0;
         s1_grid_q <= 1'b0;
         s1_col_q  <= '0;
         s1_row_q  <= '0;
      end else begin
         row_q     <= row_addr;
         s1_box_q  <= in_box;
         s1_int_q  <= in_int;
         s1_grid_q <= on_grid;
         s1_col_q  <= col_c;
         s1_row_q  <= row_c;
      end
   end

   // ---------------- Flash FSM ----------------
   flash_state_e    state_q, state_d;
   logic            phase_q, phase_d;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [TC_W-1:0] tog_cnt_q, tog_cnt_d;
   logic [ROWS-1:0] mask_q, mask_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         phase_q     <= 1'b0;
         frame_cnt_q <= '0;
         tog_cnt_q   <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         frame_cnt_q <= frame_cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         mask_q      <= mask_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      frame_cnt_d = frame_cnt_q;
      tog_cnt_d   = tog_cnt_q;
      mask_d      = mask_q;
      unique case (state_q)
         StIdle: begin
            // A frame_start coinciding with the request is deliberately not counted.
            if (flash_req) begin
               state_d     = StFlash;
               mask_d      = flash_mask;
               phase_d     = 1'b1;
               frame_cnt_d = '0;
               tog_cnt_d   = '0;
            end
         end
         StFlash: begin
            if (frame_start) begin
               if (frame_cnt_q == FC_LAST) begin
                  frame_cnt_d = '0;
                  if (tog_cnt_q == TC_LAST) begin
                     state_d   = StDone;
                     phase_d   = 1'b0;
                     tog_cnt_d = '0;
                  end else begin
                     phase_d   = ~phase_q;
                     tog_cnt_d = tog_cnt_q + TC_W'(1);
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + FC_W'(1);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign flash_busy = (state_q == StFlash);
   assign flash_done = (state_q == StDone);

   // ---------------- Stage 2: color resolution ----------------
   logic        occupied, flash_hit;
   logic [11:0] color_d, color_q;
   logic        on_board_q, is_wall_q;

   always_comb begin
      occupied  = row_data[s1_col_q];
      flash_hit = s1_int_q && mask_q[s1_row_q] && phase_q;
      color_d   = BG_COLOR;
      if (s1_box_q && !s1_int_q) begin
         color_d = WALL_COLOR;
      end else if (flash_hit) begin
         color_d = FLASH_COLOR;
      end else if (s1_int_q && occupied) begin
         color_d = CELL_COLOR;
      end else if (s1_int_q && GRID_EN && s1_grid_q) begin
         color_d = GRID_COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         color_q    <= '0;
         on_board_q <= 1'b0;
         is_wall_q  <= 1'b0;
      end else begin
         color_q    <= color_d;
         on_board_q <= s1_box_q;
         is_wall_q  <= s1_box_q && !s1_int_q;
      end
   end

   assign pix_color = color_q;
   assign on_board  = on_board_q;
   assign is_wall   = is_wall_q;

endmodule

// File: tb/tb_playfield_renderer.sv
// Self-checking bench for playfield_renderer: geometry vector table plus
// hand-written pipeline-latency, row_addr and flash-sequence scenarios.
module tb_playfield_renderer;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] xaddr;
   logic [9:0]  yaddr;
   logic        frame_start;
   logic [4:0]  row_addr;
   logic [9:0]  row_data;
   logic        flash_req;
   logic [19:0] flash_mask;
   logic        flash_busy, flash_done, on_board, is_wall;
   logic [11:0] pix_color;

   int n_checks = 0;
   int n_fail   = 0;

   logic [9:0] board [20];

   playfield_renderer #(
      .FLASH_PERIOD (2),
      .FLASH_TOGGLES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .xaddr      (xaddr),
      .yaddr      (yaddr),
      .frame_start(frame_start),
      .row_addr   (row_addr),
      .row_data   (row_data),
      .flash_req  (flash_req),
      .flash_mask (flash_mask),
      .flash_busy (flash_busy),
      .flash_done (flash_done),
      .on_board   (on_board),
      .is_wall    (is_wall),
      .pix_color  (pix_color)
   );

   always #5 clk = ~clk;

   // Synchronous board RAM model: data one cycle after the address.
   always @(posedge clk) row_data <= board[row_addr];

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [9:0]  b0;
      logic        on;
      logic        wall;
      logic [11:0] color;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic show(input logic [10:0] x, input logic [9:0] y);
      @(negedge clk);
      xaddr = x;
      yaddr = y;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic request(input logic [19:0] m);
      @(negedge clk);
      flash_req  = 1'b1;
      flash_mask = m;
      @(negedge clk);
      flash_req  = 1'b0;
      flash_mask = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{11'd470,  10'd100,  10'd0, 1'b1, 1'b1, 12'h333};
      vecs[1]  = '{11'd469,  10'd100,  10'd0, 1'b0, 1'b0, 12'h000};
      vecs[2]  = '{11'd470,  10'd99,   10'd0, 1'b0, 1'b0, 12'h000};
      vecs[3]  = '{11'd829,  10'd200,  10'd0, 1'b1, 1'b1, 12'h333};
      vecs[4]  = '{11'd830,  10'd200,  10'd0, 1'b0, 1'b0, 12'h000};
      vecs[5]  = '{11'd600,  10'd759,  10'd0, 1'b1, 1'b1, 12'h333};
      vecs[6]  = '{11'd600,  10'd760,  10'd0, 1'b0, 1'b0, 12'h000};
      vecs[7]  = '{11'd505,  10'd135,  10'd1, 1'b1, 1'b0, 12'hF80};
      vecs[8]  = '{11'd505,  10'd135,  10'd0, 1'b1, 1'b0, 12'h000};
      vecs[9]  = '{11'd500,  10'd135,  10'd0, 1'b1, 1'b0, 12'h111};
      vecs[10] = '{11'd500,  10'd135,  10'd1, 1'b1, 1'b0, 12'hF80};
      vecs[11] = '{11'd535,  10'd130,  10'd2, 1'b1, 1'b0, 12'hF80};
      vecs[12] = '{11'd535,  10'd130,  10'd0, 1'b1, 1'b0, 12'h111};
      vecs[13] = '{11'd799,  10'd729,  10'd0, 1'b1, 1'b0, 12'h000};
      vecs[14] = '{11'd800,  10'd729,  10'd0, 1'b1, 1'b1, 12'h333};
      vecs[15] = '{11'd499,  10'd300,  10'd0, 1'b1, 1'b1, 12'h333};
      vecs[16] = '{11'd2047, 10'd1023, 10'd0, 1'b0, 1'b0, 12'h000};
      vecs[17] = '{11'd0,    10'd0,    10'd0, 1'b0, 1'b0, 12'h000};

      for (int r = 0; r < 20; r++) board[r] = '0;
      rst         = 1'b1;
      xaddr       = 11'd505;
      yaddr       = 10'd705;
      frame_start = 1'b0;
      flash_req   = 1'b0;
      flash_mask  = '0;

      // Reset state, with an interior pixel on the inputs.
      repeat (3) @(negedge clk);
      check("reset pix_color", 32'(pix_color), 32'h0);
      check("reset on_board", 32'(on_board), 32'h0);
      check("reset is_wall", 32'(is_wall), 32'h0);
      check("reset row_addr", 32'(row_addr), 32'h0);
      check("reset flash_busy", 32'(flash_busy), 32'h0);
      check("reset flash_done", 32'(flash_done), 32'h0);
      rst = 1'b0;

      // row_addr follows interior rows, holds outside the interior.
      @(negedge clk);
      xaddr = 11'd505; yaddr = 10'd705;
      #1 check("row_addr row19", 32'(row_addr), 32'd19);
      @(negedge clk);
      xaddr = 11'd0; yaddr = 10'd0;
      #1 check("row_addr hold", 32'(row_addr), 32'd19);
      @(negedge clk);
      xaddr = 11'd505; yaddr = 10'd135;
      #1 check("row_addr row0", 32'(row_addr), 32'd0);

      // Geometry / color table.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         board[0] = vecs[i].b0;
         show(vecs[i].x, vecs[i].y);
         check($sformatf("vec%0d on_board", i), 32'(on_board), 32'(vecs[i].on));
         check($sformatf("vec%0d is_wall", i), 32'(is_wall), 32'(vecs[i].wall));
         check($sformatf("vec%0d pix_color", i), 32'(pix_color), 32'(vecs[i].color));
      end

      // Back-to-back pixels: exactly two cycles of latency.
      @(negedge clk);
      board[0] = 10'b1;
      xaddr = 11'd470; yaddr = 10'd100;
      @(negedge clk);
      xaddr = 11'd469; yaddr = 10'd100;
      @(negedge clk);
      check("lat A color", 32'(pix_color), 32'h333);
      xaddr = 11'd505; yaddr = 10'd135;
      @(negedge clk);
      check("lat B on_board", 32'(on_board), 32'h0);
      check("lat B color", 32'(pix_color), 32'h0);
      xaddr = 11'd535; yaddr = 10'd140;
      @(negedge clk);
      check("lat C color", 32'(pix_color), 32'hF80);
      @(negedge clk);
      check("lat D color", 32'(pix_color), 32'h000);
      check("lat D on_board", 32'(on_board), 32'h1);
      board[0] = '0;

      // Flash sequence on row 19; row 18 must stay dark.
      xaddr = 11'd505; yaddr = 10'd705;
      request(20'h80000);
      check("flash1 busy", 32'(flash_busy), 32'h1);
      check("flash1 done idle", 32'(flash_done), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check("flash1 row19 on", 32'(pix_color), 32'hFFF);
      show(11'd505, 10'd675);
      check("flash1 row18 off", 32'(pix_color), 32'h000);
      show(11'd505, 10'd705);
      pulse_fs();
      check("flash1 busy fs1", 32'(flash_busy), 32'h1);
      request(20'h40000);
      show(11'd505, 10'd675);
      check("flash1 new mask ignored", 32'(pix_color), 32'h000);
      show(11'd505, 10'd705);
      check("flash1 row19 still on", 32'(pix_color), 32'hFFF);
      pulse_fs();
      @(posedge clk); @(posedge clk); #1;
      check("flash1 row19 phase0", 32'(pix_color), 32'h000);
      pulse_fs();
      check("flash1 busy fs3", 32'(flash_busy), 32'h1);
      check("flash1 no done fs3", 32'(flash_done), 32'h0);
      pulse_fs();
      check("flash1 done", 32'(flash_done), 32'h1);
      check("flash1 busy at done", 32'(flash_busy), 32'h0);
      flash_req  = 1'b1;
      flash_mask = 20'h80000;
      @(negedge clk);
      flash_req  = 1'b0;
      flash_mask = '0;
      check("done pulse one cycle", 32'(flash_done), 32'h0);
      check("req in done ignored", 32'(flash_busy), 32'h0);

      // Request together with frame_start: that frame_start is not counted.
      @(negedge clk);
      flash_req = 1'b1; frame_start = 1'b1; flash_mask = 20'h80000;
      @(negedge clk);
      flash_req = 1'b0; frame_start = 1'b0; flash_mask = '0;
      check("simul busy", 32'(flash_busy), 32'h1);
      repeat (3) pulse_fs();
      check("simul busy fs3", 32'(flash_busy), 32'h1);
      pulse_fs();
      check("simul done", 32'(flash_done), 32'h1);

      // Reset mid-sequence, then restart.
      request(20'h80000);
      repeat (3) pulse_fs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst busy", 32'(flash_busy), 32'h0);
      check("rst done", 32'(flash_done), 32'h0);
      check("rst pix_color", 32'(pix_color), 32'h0);
      check("rst on_board", 32'(on_board), 32'h0);
      @(negedge clk);
      check("rst no done later", 32'(flash_done), 32'h0);
      request(20'h80000);
      check("restart busy", 32'(flash_busy), 32'h1);
      @(posedge clk); @(posedge clk); #1;
      check("restart phase1", 32'(pix_color), 32'hFFF);
      repeat (3) pulse_fs();
      check("restart busy fs3", 32'(flash_busy), 32'h1);
      pulse_fs();
      check("restart done", 32'(flash_done), 32'h1);

      // Empty mask: full sequence, nothing visible.
      request(20'h0);
      check("mask0 busy", 32'(flash_busy), 32'h1);
      @(posedge clk); @(posedge clk); #1;
      check("mask0 dark", 32'(pix_color), 32'h000);
      repeat (4) pulse_fs();
      check("mask0 done", 32'(flash_done), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
